// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the block-to-beat memory port arbiter.
// Imported by rr_arbiter and mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR,
        WR_DONE,
        RESP
    } arbStateT;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_SUBBLOCKS = 4;

    function automatic int beatWidth(input int blockW, input int subblocks);
        return blockW / subblocks;
    endfunction

    function automatic int strbWidth(input int subblocks);
        return (subblocks > 1) ? $clog2(subblocks) : 1;
    endfunction

    // A single port still needs a one-bit pointer to keep the vectors legal.
    function automatic int ptrWidth(input int numPorts);
        return (numPorts > 1) ? $clog2(numPorts) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting port strictly after ptr, wrapping.
// The pointer register is owned by the instantiating module.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PTR_W     = ptrWidth(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     grantIdx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scanning ptr+1 .. ptr+NUM_PORTS puts the last winner at lowest priority.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_PORTS);
            if (en && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter putting NUM_PORTS block requesters onto a beat-strobed memory bus,
// one transaction at a time. Define MEM_PERF_CNT_EN to add perf_rd/perf_wr/perf_stall.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = 32,
    parameter int BLOCK_W   = 512,
    parameter int SUBBLOCKS = DEF_SUBBLOCKS,
    parameter int STRB_W    = strbWidth(SUBBLOCKS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS-1:0]           req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS*BLOCK_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [BLOCK_W-1:0]             rsp_rdata,
    output logic [ADDR_W-1:0]              addrD,
    output logic                           enD,
    output logic                           weD,
    output logic [STRB_W-1:0]              doutDstrobe,
    output logic [BLOCK_W/SUBBLOCKS-1:0]   doutD,
    input  logic [STRB_W-1:0]              dinDstrobe,
    input  logic [BLOCK_W/SUBBLOCKS-1:0]   dinD,
    input  logic                           readyD,
    input  logic                           accR,
    input  logic                           accW
`ifdef MEM_PERF_CNT_EN
    , output logic [31:0]                  perf_rd
    , output logic [31:0]                  perf_wr
    , output logic [31:0]                  perf_stall
`endif
);

    localparam int BEAT_W = beatWidth(BLOCK_W, SUBBLOCKS);
    localparam int PTR_W  = ptrWidth(NUM_PORTS);
    localparam logic [STRB_W-1:0] LAST_BEAT = STRB_W'(SUBBLOCKS - 1);

    arbStateT               state, stateNext;
    logic [PTR_W-1:0]       rrPtr;
    logic [STRB_W-1:0]      beatCnt;
    logic [SUBBLOCKS-1:0]   rxMask;
    logic [SUBBLOCKS-1:0]   strbHot;
    logic [ADDR_W-1:0]      latAddr;
    logic [BLOCK_W-1:0]     latData;
    logic [BLOCK_W-1:0]     rxBuf;
    logic [BLOCK_W-1:0]     mergedBuf;
    logic [BEAT_W-1:0]      beatSel;
    logic [NUM_PORTS-1:0]   grantVec;
    logic [PTR_W-1:0]       grantIdx;
    logic [ADDR_W-1:0]      selAddr;
    logic [BLOCK_W-1:0]     selData;
    logic                   selWe;
    logic                   grantNow;
    logic                   rxDone;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) uArb (
        .req      (req_valid),
        .ptr      (rrPtr),
        .en       (state == IDLE),
        .grant    (grantVec),
        .grantIdx (grantIdx)
    );

    assign grantNow = (state == IDLE) && (|req_valid);

    always_comb begin
        selAddr = '0;
        selData = '0;
        selWe   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grantIdx == PTR_W'(p)) begin
                selAddr = req_addr[p*ADDR_W +: ADDR_W];
                selData = req_wdata[p*BLOCK_W +: BLOCK_W];
                selWe   = req_we[p];
            end
        end
    end

    // Incoming beat merged into the assembly buffer; the mask only tracks coverage.
    always_comb begin
        strbHot = '0;
        if (readyD) strbHot[dinDstrobe] = 1'b1;
        for (int s = 0; s < SUBBLOCKS; s++) begin
            mergedBuf[s*BEAT_W +: BEAT_W] = strbHot[s] ? dinD : rxBuf[s*BEAT_W +: BEAT_W];
        end
    end

    assign rxDone = (state == RD_DATA) && readyD && (&(rxMask | strbHot));

    always_comb begin
        beatSel = '0;
        for (int s = 0; s < SUBBLOCKS; s++) begin
            if (beatCnt == STRB_W'(s)) beatSel = latData[s*BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        req_ready   = '0;
        rsp_valid   = '0;
        addrD       = '0;
        enD         = 1'b0;
        weD         = 1'b0;
        doutDstrobe = '0;
        doutD       = '0;
        case (state)
            IDLE: begin
                // Gated so nothing leaks out while reset is held with requests pending.
                req_ready = grantVec & {NUM_PORTS{reset}};
                if (grantNow) stateNext = selWe ? WR : RD_REQ;
            end
            RD_REQ: begin
                enD   = 1'b1;
                addrD = latAddr;
                if (accR) stateNext = RD_DATA;
            end
            RD_DATA: begin
                if (rxDone) stateNext = RESP;
            end
            WR: begin
                weD         = 1'b1;
                addrD       = latAddr;
                doutDstrobe = beatCnt;
                doutD       = beatSel;
                if (accW && beatCnt == LAST_BEAT) stateNext = WR_DONE;
            end
            WR_DONE: begin
                if (readyD) stateNext = RESP;
            end
            RESP: begin
                rsp_valid = NUM_PORTS'(1) << rrPtr;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr     <= PTR_W'(NUM_PORTS - 1);
            beatCnt   <= '0;
            rxMask    <= '0;
            rsp_rdata <= '0;
        end else begin
            if (grantNow) begin
                rrPtr   <= grantIdx;
                beatCnt <= '0;
            end
            if (state == RD_REQ && accR)    rxMask  <= '0;
            if (state == RD_DATA && readyD) rxMask  <= rxMask | strbHot;
            if (state == WR && accW)        beatCnt <= beatCnt + 1'b1;
            if (rxDone)                     rsp_rdata <= mergedBuf;
        end
    end

    always_ff @(posedge clk) begin
        if (grantNow) begin
            latAddr <= selAddr;
            latData <= selData;
        end
        if (state == RD_DATA && readyD) rxBuf <= mergedBuf;
    end

`ifdef MEM_PERF_CNT_EN
    logic perfIsWrite;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfIsWrite <= 1'b0;
            perf_rd     <= '0;
            perf_wr     <= '0;
            perf_stall  <= '0;
        end else begin
            if (grantNow) perfIsWrite <= selWe;
            if (state == RESP && !perfIsWrite) perf_rd <= satInc(perf_rd);
            if (state == RESP &&  perfIsWrite) perf_wr <= satInc(perf_wr);
            if ((state == RD_REQ && !accR) || (state == WR && !accW))
                perf_stall <= satInc(perf_stall);
        end
    end
`endif

endmodule
